mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory bus between the pipeline's instruction fetch (IF) and data load/store (MEM) stages.
- Sequences bus transactions with a small FSM and drives per-stage stall signals.
- The pipeline hazard unit ORs these stalls into its freeze/flush logic.
- Sits between cpu and the external memory model; replaces the separate fetch and load/store ports.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/arb_perf_counter.sv | 17 +
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state encoding and the issue-priority helper.
package mem_port_arbiter_pkg;

    localparam int ARB_ST_W = 2;

    typedef enum logic [ARB_ST_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    // Data accesses belong to the older instruction, so they always win over fetch.
    function automatic arb_state_t issue_target(input logic data_pend, input logic fetch_pend);
        if (data_pend) begin
            return ARB_DATA;
        end else if (fetch_pend) begin
            return ARB_FETCH;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// Saturating 32-bit event counter; counts every enabled cycle, async active-low reset.
module arb_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory bus between IF and MEM stages.
// Optional stall counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W      = 32,
    parameter int MASK_W = W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [W-1:0]      if_addr,
    output logic [W-1:0]      if_inst,
    output logic              if_stall,
    input  logic              d_load_en,
    input  logic              d_store_en,
    input  logic [W-1:0]      d_addr,
    input  logic [W-1:0]      d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic [W-1:0]      d_rdata,
    output logic              d_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [W-1:0]      bus_addr,
    output logic [W-1:0]      bus_wdata,
    output logic [MASK_W-1:0] bus_wmask,
    input  logic              bus_ack,
    input  logic [W-1:0]      bus_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_d_stall_cnt,
`endif
    output logic [ARB_ST_W-1:0] dbg_state
);

    // Bus handshake: bus_req rises on the issue edge with all bus fields registered;
    // the fields hold until the slave raises bus_ack for one cycle (the done cycle).
    arb_state_t  state_q, state_d;
    logic        done_fetch, done_data;
    logic        data_pend, fetch_pend;
    logic        issue;
    logic        fetch_keep, load_keep;
    logic [W-1:0] if_inst_q, d_rdata_q;

    assign done_fetch = (state_q == ARB_FETCH) && bus_ack;
    assign done_data  = (state_q == ARB_DATA) && bus_ack;

    // The request completing this cycle is not pending again for the chained issue.
    assign data_pend  = (d_load_en || d_store_en) && !done_data;
    assign fetch_pend = if_req && !done_fetch;

    // A withdrawn request still finishes on the bus but its result is dropped.
    assign fetch_keep = done_fetch && if_req;
    assign load_keep  = done_data && !bus_we && d_load_en;

    assign if_stall = if_req && !done_fetch;
    assign d_stall  = (d_load_en || d_store_en) && !done_data;

    assign if_inst   = fetch_keep ? bus_rdata : if_inst_q;
    assign d_rdata   = load_keep ? bus_rdata : d_rdata_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if ((state_q == ARB_IDLE) || done_fetch || done_data) begin
            state_d = issue_target(data_pend, fetch_pend);
            issue   = (state_d != ARB_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= '0;
            if_inst_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                bus_req <= 1'b1;
                if (state_d == ARB_DATA) begin
                    bus_we    <= d_store_en;
                    bus_addr  <= d_addr;
                    bus_wdata <= d_wdata;
                    bus_wmask <= d_wmask;
                end else begin
                    bus_we    <= 1'b0;
                    bus_addr  <= if_addr;
                    bus_wdata <= '0;
                    bus_wmask <= '0;
                end
            end else if (done_fetch || done_data) begin
                bus_req <= 1'b0;
            end
            if (fetch_keep) begin
                if_inst_q <= bus_rdata;
            end
            if (load_keep) begin
                d_rdata_q <= bus_rdata;
            end
        end
    end

`ifndef SYNTHESIS
    // Both enables together are resolved as a store, but indicate an upstream bug.
    a_ld_st_excl: assert property (@(posedge clk) disable iff (!rst) !(d_load_en && d_store_en));
`endif

`ifdef MEM_ARB_PERF_EN
    arb_perf_counter u_if_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (if_stall),
        .count (perf_if_stall_cnt)
    );

    arb_perf_counter u_d_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (d_stall),
        .count (perf_d_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized IF/MEM traffic
// against a memory model and a random-latency bus slave.
module tb_mem_port_arbiter;

    localparam int W = 32;
    localparam int MW = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [W-1:0]  if_addr = '0;
    logic          d_load_en = 1'b0;
    logic          d_store_en = 1'b0;
    logic [W-1:0]  d_addr = '0;
    logic [W-1:0]  d_wdata = '0;
    logic [MW-1:0] d_wmask = '0;
    logic          bus_ack;
    logic [W-1:0]  bus_rdata;
    wire  [W-1:0]  if_inst, d_rdata, bus_addr, bus_wdata;
    wire           if_stall, d_stall, bus_req, bus_we;
    wire  [MW-1:0] bus_wmask;
    wire  [1:0]    dbg_state;
`ifdef MEM_ARB_PERF_EN
    wire  [31:0]   perf_if_stall_cnt, perf_d_stall_cnt;
`endif

    // Bus slave: manual control in directed tests, random latency otherwise.
    logic          auto_slave = 1'b0;
    logic          m_ack = 1'b0, s_ack = 1'b0;
    logic [W-1:0]  m_rdata = '0, s_rdata = '0;
    assign bus_ack   = auto_slave ? s_ack : m_ack;
    assign bus_rdata = auto_slave ? s_rdata : m_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [W-1:0] slave_mem [32];
    logic [W-1:0] model_mem [32];

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_inst    (if_inst),
        .if_stall   (if_stall),
        .d_load_en  (d_load_en),
        .d_store_en (d_store_en),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_d_stall_cnt  (perf_d_stall_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(input int i);
        return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [W-1:0] apply_mask(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                                 input logic [MW-1:0] m);
        logic [W-1:0] r;
        r = old_v;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    // Random-latency slave; checks that bus fields hold while a transaction is open.
    initial begin
        int rem;
        logic [W-1:0] l_addr, l_wdata;
        logic l_we;
        logic [MW-1:0] l_mask;
        logic [4:0] idx;
        rem = 0;
        l_addr = '0; l_wdata = '0; l_we = 1'b0; l_mask = '0;
        for (int i = 0; i < 32; i++) slave_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            #1;
            s_ack = 1'b0;
            if (!auto_slave || !rst) begin
                rem = 0;
            end else if (bus_req) begin
                if (rem == 0) begin
                    rem = $urandom_range(1, 3);
                    l_addr = bus_addr; l_we = bus_we; l_wdata = bus_wdata; l_mask = bus_wmask;
                end else begin
                    total_cnt++;
                    if ({bus_addr, bus_we, bus_wdata, bus_wmask} !== {l_addr, l_we, l_wdata, l_mask})
                        $display("FAIL bus_hold: got addr=%h we=%b wd=%h m=%h, required addr=%h we=%b wd=%h m=%h",
                                 bus_addr, bus_we, bus_wdata, bus_wmask, l_addr, l_we, l_wdata, l_mask);
                    else pass_cnt++;
                end
                rem--;
                if (rem == 0) begin
                    idx = bus_addr[6:2];
                    s_ack = 1'b1;
                    s_rdata = slave_mem[idx];
                    if (bus_we) slave_mem[idx] = apply_mask(slave_mem[idx], bus_wdata, bus_wmask);
                end
            end
        end
    end

    task automatic test_reset();
        if_req = 1'b1;
        #3;
        total_cnt++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wmask} !== '0)
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wd=%h m=%h, required all zero",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_wmask);
        else pass_cnt++;
        total_cnt++;
        if (if_inst !== 32'h0 || d_rdata !== 32'h0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_regs: got if_inst=%h d_rdata=%h state=%0d, required 0/0/0",
                     if_inst, d_rdata, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (if_stall !== 1'b1 || d_stall !== 1'b0)
            $display("FAIL reset_stalls: got if_stall=%b d_stall=%b, required 1/0", if_stall, d_stall);
        else pass_cnt++;
        if_req = 1'b0;
        #4 rst = 1'b1;
    endtask

    task automatic test_fetch();
        cyc();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        total_cnt++;
        if (if_stall !== 1'b1) $display("FAIL fetch_stall_idle: got %b, required 1", if_stall);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h100 || dbg_state !== ST_FETCH)
            $display("FAIL fetch_issue: got req=%b we=%b addr=%h st=%0d, required 1/0/00000100/1",
                     bus_req, bus_we, bus_addr, dbg_state);
        else pass_cnt++;
        m_ack = 1'b1; m_rdata = 32'h2402_000A;
        @(negedge clk);
        total_cnt++;
        if (if_stall !== 1'b0 || if_inst !== 32'h2402_000A)
            $display("FAIL fetch_done: got stall=%b inst=%h, required 0/2402000a", if_stall, if_inst);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0; m_rdata = 32'h0; if_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (if_inst !== 32'h2402_000A || bus_req !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL fetch_hold: got inst=%h req=%b st=%0d, required 2402000a/0/0",
                     if_inst, bus_req, dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        cyc();
        if_req = 1'b1; if_addr = 32'h104;
        d_load_en = 1'b1; d_addr = 32'h2000;
        @(negedge clk);
        total_cnt++;
        if (if_stall !== 1'b1 || d_stall !== 1'b1)
            $display("FAIL sim_stall_idle: got if=%b d=%b, required 1/1", if_stall, d_stall);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus_addr !== 32'h2000 || dbg_state !== ST_DATA || bus_we !== 1'b0)
            $display("FAIL sim_data_first: got addr=%h st=%0d we=%b, required 00002000/2/0",
                     bus_addr, dbg_state, bus_we);
        else pass_cnt++;
        cyc();
        cyc();
        m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
        @(negedge clk);
        total_cnt++;
        if (d_stall !== 1'b0 || if_stall !== 1'b1 || d_rdata !== 32'hCAFE_0001)
            $display("FAIL sim_load_done: got d_stall=%b if_stall=%b d_rdata=%h, required 0/1/cafe0001",
                     d_stall, if_stall, d_rdata);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0; d_load_en = 1'b0;
        total_cnt++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h104 || dbg_state !== ST_FETCH)
            $display("FAIL sim_chain: got req=%b addr=%h st=%0d, required 1/00000104/1",
                     bus_req, bus_addr, dbg_state);
        else pass_cnt++;
        cyc();
        cyc();
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        total_cnt++;
        if (if_stall !== 1'b0 || if_inst !== 32'h1234_5678 || d_rdata !== 32'hCAFE_0001)
            $display("FAIL sim_fetch_done: got stall=%b inst=%h d_rdata=%h, required 0/12345678/cafe0001",
                     if_stall, if_inst, d_rdata);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0; if_req = 1'b0;
        total_cnt++;
        if (bus_req !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL sim_idle: got req=%b st=%0d, required 0/0", bus_req, dbg_state);
        else pass_cnt++;
`ifdef MEM_ARB_PERF_EN
        total_cnt++;
        if (perf_d_stall_cnt !== 32'd3 || perf_if_stall_cnt !== 32'd6)
            $display("FAIL perf_counts: got d=%0d if=%0d, required 3/6", perf_d_stall_cnt, perf_if_stall_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_store();
        d_store_en = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        cyc();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin
                m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            total_cnt++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h2004 ||
                bus_wdata !== 32'hDEAD_BEEF || bus_wmask !== 4'b0011)
                $display("FAIL store_fields_c%0d: got req=%b we=%b addr=%h wd=%h m=%b, required 1/1/00002004/deadbeef/0011",
                         c, bus_req, bus_we, bus_addr, bus_wdata, bus_wmask);
            else pass_cnt++;
            if (c == 0) cyc();
        end
        total_cnt++;
        if (d_stall !== 1'b0 || d_rdata !== 32'hCAFE_0001)
            $display("FAIL store_done: got stall=%b d_rdata=%h, required 0/cafe0001", d_stall, d_rdata);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0; d_store_en = 1'b0;
        total_cnt++;
        if (d_rdata !== 32'hCAFE_0001 || bus_req !== 1'b0)
            $display("FAIL store_after: got d_rdata=%h req=%b, required cafe0001/0", d_rdata, bus_req);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h200;
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b1 || dbg_state !== ST_FETCH || if_stall !== 1'b0)
            $display("FAIL flush_hold: got req=%b st=%0d stall=%b, required 1/1/0", bus_req, dbg_state, if_stall);
        else pass_cnt++;
        cyc();
        m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        total_cnt++;
        if (if_inst !== 32'h1234_5678)
            $display("FAIL flush_ack_inst: got %h, required 12345678", if_inst);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0;
        total_cnt++;
        if (if_inst !== 32'h1234_5678 || dbg_state !== ST_IDLE || bus_req !== 1'b0)
            $display("FAIL flush_after: got inst=%h st=%0d req=%b, required 12345678/0/0",
                     if_inst, dbg_state, bus_req);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        d_load_en = 1'b1; d_addr = 32'h2500;
        cyc();
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (bus_req !== 1'b0 || dbg_state !== ST_IDLE || d_rdata !== 32'h0)
            $display("FAIL arst_mid: got req=%b st=%0d d_rdata=%h, required 0/0/0", bus_req, dbg_state, d_rdata);
        else pass_cnt++;
        #1 rst = 1'b1;
        d_addr = 32'h3000;
        cyc();
        total_cnt++;
        if (bus_addr !== 32'h3000 || dbg_state !== ST_DATA || bus_req !== 1'b1)
            $display("FAIL arst_reissue: got addr=%h st=%0d req=%b, required 00003000/2/1", bus_addr, dbg_state, bus_req);
        else pass_cnt++;
        cyc();
        m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        total_cnt++;
        if (d_stall !== 1'b0 || d_rdata !== 32'h0BAD_F00D)
            $display("FAIL arst_load_done: got stall=%b d_rdata=%h, required 0/0badf00d", d_stall, d_rdata);
        else pass_cnt++;
        cyc();
        m_ack = 1'b0; d_load_en = 1'b0;
        total_cnt++;
        if (d_rdata !== 32'h0BAD_F00D || bus_req !== 1'b0)
            $display("FAIL arst_hold: got d_rdata=%h req=%b, required 0badf00d/0", d_rdata, bus_req);
        else pass_cnt++;
    endtask

    // Pipeline model: fetch region is words 0..15 (never written), data region 16..31.
    task automatic test_random_traffic();
        for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
        auto_slave = 1'b1;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    int k;
                    int wi;
                    wi = $urandom_range(0, 15);
                    if_addr = 32'(wi * 4); if_req = 1'b1;
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (if_stall && k < 50);
                    total_cnt++;
                    if (if_stall || if_inst !== model_mem[wi])
                        $display("FAIL rand_fetch_%0d: got stall=%b inst=%h, required 0/%h",
                                 n, if_stall, if_inst, model_mem[wi]);
                    else pass_cnt++;
                    cyc();
                    if_req = 1'b0;
                    repeat ($urandom_range(0, 2)) cyc();
                end
            end
            begin
                for (int n = 0; n < 25; n++) begin
                    int k;
                    int wi;
                    logic st;
                    wi = $urandom_range(16, 31);
                    st = 1'($urandom_range(0, 1));
                    d_addr = 32'(wi * 4); d_wdata = $urandom; d_wmask = 4'($urandom_range(1, 15));
                    d_store_en = st; d_load_en = !st;
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (d_stall && k < 50);
                    total_cnt++;
                    if (d_stall) begin
                        $display("FAIL rand_data_timeout_%0d: got stall=1, required 0 within 50 cycles", n);
                    end else if (st) begin
                        model_mem[wi] = apply_mask(model_mem[wi], d_wdata, d_wmask);
                        pass_cnt++;
                    end else if (d_rdata !== model_mem[wi]) begin
                        $display("FAIL rand_load_%0d: got %h, required %h", n, d_rdata, model_mem[wi]);
                    end else pass_cnt++;
                    cyc();
                    d_load_en = 1'b0; d_store_en = 1'b0;
                    repeat ($urandom_range(0, 2)) cyc();
                end
            end
        join
        repeat (5) cyc();
        // Read back every data word through the arbiter to catch bad write merges.
        for (int wi = 16; wi < 32; wi++) begin
            int k;
            d_addr = 32'(wi * 4); d_load_en = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (d_stall && k < 50);
            total_cnt++;
            if (d_stall || d_rdata !== model_mem[wi])
                $display("FAIL readback_%0d: got stall=%b data=%h, required 0/%h", wi, d_stall, d_rdata, model_mem[wi]);
            else pass_cnt++;
            cyc();
            d_load_en = 1'b0;
        end
        auto_slave = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_flush();
        test_async_reset();
        test_random_traffic();
        repeat (2) cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
